// File: rtl/countdown_pkg.sv
// Shared types and constants for the min:sec countdown timer.
package countdown_pkg;

  localparam int unsigned TIME_W  = 8;
  localparam int unsigned SEC_MAX = 59;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  // Width of a counter that must hold values 0..ticks-1 (at least 1 bit).
  function automatic int unsigned alarm_cnt_w(input int unsigned ticks);
    if (ticks <= 1) return 1;
    return int'($clog2(ticks));
  endfunction

endpackage

// File: rtl/countdown_timer_down_counter.sv
// Loadable mod-MODULUS down counter with wrap borrow.
// Ports: clk, RESET (async active-low), en (decrement), load/load_val (preset,
// has priority over en), count (registered value), zero (count == 0),
// borrow (one-cycle pulse, registered, when an enabled decrement wraps 0 -> MODULUS-1).
module down_counter_mod
  import countdown_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              en,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic [TIME_W-1:0] count,
  output logic              zero,
  output logic              borrow
);

  logic [TIME_W-1:0] w_count_nxt;
  logic              w_borrow_nxt;

  // Next count: load beats decrement; decrement wraps at zero.
  always_comb begin
    w_count_nxt  = count;
    w_borrow_nxt = 1'b0;
    if (load) begin
      w_count_nxt = load_val;
    end else if (en) begin
      if (count == '0) begin
        w_count_nxt  = TIME_W'(MODULUS - 1);
        w_borrow_nxt = 1'b1;
      end else begin
        w_count_nxt = count - TIME_W'(1);
      end
    end
  end

  // zero is registered alongside count so it always matches the stored value.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      count  <= '0;
      zero   <= 1'b1;
      borrow <= 1'b0;
    end else begin
      count  <= w_count_nxt;
      zero   <= (w_count_nxt == '0);
      borrow <= w_borrow_nxt;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Countdown (min:sec) timer with alarm.
// Ports: clk, RESET (async active-low), tick (1 Hz one-cycle enable),
// load/load_min/load_sec (clamped presets), start/pause (pulses),
// sec_num/min_num (current time), borrow (seconds wrap pulse),
// running (RUN), alarm (ALARM), done (RUN->ALARM pulse). All outputs registered.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned MAX_MIN     = 59,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              tick,
  input  logic              load,
  input  logic [TIME_W-1:0] load_min,
  input  logic [TIME_W-1:0] load_sec,
  input  logic              start,
  input  logic              pause,
  output logic [TIME_W-1:0] sec_num,
  output logic [TIME_W-1:0] min_num,
  output logic              borrow,
  output logic              running,
  output logic              alarm,
  output logic              done
);

  localparam int unsigned ACW = alarm_cnt_w(ALARM_TICKS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TIME_W-1:0] r_min;
  logic [ACW-1:0]    r_alm_cnt;
  logic              r_running;
  logic              r_alarm;
  logic              r_done;

  logic [TIME_W-1:0] w_sec;
  logic              w_sec_zero;
  logic              w_min_zero;
  logic              w_time_zero;
  logic              w_hit_zero;
  logic [TIME_W-1:0] w_clamp_min;
  logic [TIME_W-1:0] w_clamp_sec;
  logic              w_load_en;
  logic              w_sec_en;
  logic              w_min_dec;
  logic              w_done_nxt;
  logic [ACW-1:0]    w_alm_cnt_nxt;

  assign w_min_zero  = (r_min == '0);
  assign w_time_zero = w_sec_zero && w_min_zero;
  // In RUN a tick reaches 00:00 only from 00:01.
  assign w_hit_zero  = (r_state == ST_RUN) && tick && w_min_zero && (w_sec == TIME_W'(1));
  assign w_clamp_min = (load_min > TIME_W'(MAX_MIN)) ? TIME_W'(MAX_MIN) : load_min;
  assign w_clamp_sec = (load_sec > TIME_W'(SEC_MAX)) ? TIME_W'(SEC_MAX) : load_sec;

  // State register.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; pause always beats start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_PAUSED: begin
        if (!pause && start && !w_time_zero) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_hit_zero)  w_state_nxt = ST_ALARM;
        else if (pause)  w_state_nxt = ST_PAUSED;
      end
      ST_ALARM: begin
        if (start || pause || load) w_state_nxt = ST_IDLE;
        else if (tick && (r_alm_cnt == ACW'(ALARM_TICKS - 1))) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath controls derived from state and inputs.
  always_comb begin
    w_load_en     = load && (r_state != ST_RUN);
    w_sec_en      = (r_state == ST_RUN) && tick && !w_time_zero;
    w_min_dec     = w_sec_en && w_sec_zero;
    w_done_nxt    = (r_state == ST_RUN) && (w_state_nxt == ST_ALARM);
    w_alm_cnt_nxt = r_alm_cnt;
    if (w_state_nxt != ST_ALARM)                w_alm_cnt_nxt = '0;
    else if ((r_state == ST_ALARM) && tick)     w_alm_cnt_nxt = r_alm_cnt + ACW'(1);
  end

  // Minutes, alarm tick counter and status outputs.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_min     <= '0;
      r_alm_cnt <= '0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_load_en)      r_min <= w_clamp_min;
      else if (w_min_dec) r_min <= r_min - TIME_W'(1);
      r_alm_cnt <= w_alm_cnt_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_alarm   <= (w_state_nxt == ST_ALARM);
      r_done    <= w_done_nxt;
    end
  end

  down_counter_mod #(
    .MODULUS (SEC_MAX + 1)
  ) u_sec (
    .clk      (clk),
    .RESET    (RESET),
    .en       (w_sec_en),
    .load     (w_load_en),
    .load_val (w_clamp_sec),
    .count    (w_sec),
    .zero     (w_sec_zero),
    .borrow   (borrow)
  );

  assign sec_num = w_sec;
  assign min_num = r_min;
  assign running = r_running;
  assign alarm   = r_alarm;
  assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer (MAX_MIN=59, ALARM_TICKS=10).
module tb_countdown_timer;
  import countdown_pkg::*;

  logic       clk = 1'b0;
  logic       RESET;
  logic       tick, load, start, pause;
  logic [7:0] load_min, load_sec;
  logic [7:0] sec_num, min_num;
  logic       borrow, running, alarm, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit     t, l, s, p;
    int     lmin, lsec;
    int     emin, esec;
    bit     eb, er, ea, ed;
    state_t st;
  } vec_t;

  vec_t q[$];

  countdown_timer #(.MAX_MIN(59), .ALARM_TICKS(10)) dut (
    .clk(clk), .RESET(RESET), .tick(tick), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
    .sec_num(sec_num), .min_num(min_num), .borrow(borrow),
    .running(running), .alarm(alarm), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit t, l, s, p, input int lmin, lsec, emin, esec,
                     input bit eb, er, ea, ed, input state_t st);
    vec_t v;
    v.t = t; v.l = l; v.s = s; v.p = p;
    v.lmin = lmin; v.lsec = lsec; v.emin = emin; v.esec = esec;
    v.eb = eb; v.er = er; v.ea = ea; v.ed = ed; v.st = st;
    q.push_back(v);
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, "/min"}, int'(min_num), v.emin);
    chk({tag, "/sec"}, int'(sec_num), v.esec);
    chk({tag, "/borrow"}, int'(borrow), int'(v.eb));
    chk({tag, "/running"}, int'(running), int'(v.er));
    chk({tag, "/alarm"}, int'(alarm), int'(v.ea));
    chk({tag, "/done"}, int'(done), int'(v.ed));
    chk({tag, "/state"}, int'(dut.r_state), int'(v.st));
  endtask

  // Called #1 after a rising edge: drive, cross one edge, sample #1 after it.
  task automatic apply(input string tag, input vec_t v);
    tick = v.t; load = v.l; start = v.s; pause = v.p;
    load_min = 8'(v.lmin); load_sec = 8'(v.lsec);
    @(posedge clk); #1;
    tick = 0; load = 0; start = 0; pause = 0;
    check_all(tag, v);
  endtask

  initial begin
    vec_t z;
    RESET = 1'b0;
    tick = 0; load = 0; start = 0; pause = 0; load_min = 0; load_sec = 0;

    //   t l s p  lmin lsec  emin esec b r a d  state
    add(0,1,0,0,   1,   2,    1,   2, 0,0,0,0, ST_IDLE);
    add(0,0,1,0,   0,   0,    1,   2, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,    1,   1, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,    1,   0, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,    0,  59, 1,1,0,0, ST_RUN);
    add(0,0,0,0,   0,   0,    0,  59, 0,1,0,0, ST_RUN);
    add(0,0,0,1,   0,   0,    0,  59, 0,0,0,0, ST_PAUSED);
    add(0,1,0,0,   0,   2,    0,   2, 0,0,0,0, ST_PAUSED);
    add(0,0,1,0,   0,   0,    0,   2, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,    0,   1, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,    0,   0, 0,0,1,1, ST_ALARM);
    add(0,0,0,0,   0,   0,    0,   0, 0,0,1,0, ST_ALARM);
    for (int k = 0; k < 9; k++)
      add(1,0,0,0, 0,   0,    0,   0, 0,0,1,0, ST_ALARM);
    add(1,0,0,0,   0,   0,    0,   0, 0,0,0,0, ST_IDLE);
    // pause together with tick
    add(0,1,0,0,   0,   5,    0,   5, 0,0,0,0, ST_IDLE);
    add(0,0,1,0,   0,   0,    0,   5, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,    0,   4, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,    0,   3, 0,1,0,0, ST_RUN);
    add(1,0,0,1,   0,   0,    0,   2, 0,0,0,0, ST_PAUSED);
    add(1,0,0,0,   0,   0,    0,   2, 0,0,0,0, ST_PAUSED);
    add(1,0,0,0,   0,   0,    0,   2, 0,0,0,0, ST_PAUSED);
    add(0,0,1,0,   0,   0,    0,   2, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,    0,   1, 0,1,0,0, ST_RUN);
    add(0,0,0,1,   0,   0,    0,   1, 0,0,0,0, ST_PAUSED);
    // clamping, load ignored in RUN, start at 00:00
    add(0,1,0,0, 200,  75,   59,  59, 0,0,0,0, ST_PAUSED);
    add(0,0,1,0,   0,   0,   59,  59, 0,1,0,0, ST_RUN);
    add(0,1,0,0,   0,   5,   59,  59, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,   59,  58, 0,1,0,0, ST_RUN);
    add(0,0,0,1,   0,   0,   59,  58, 0,0,0,0, ST_PAUSED);
    add(0,1,0,0,   0,   0,    0,   0, 0,0,0,0, ST_PAUSED);
    add(0,0,1,0,   0,   0,    0,   0, 0,0,0,0, ST_PAUSED);
    // load acknowledges alarm
    add(0,1,0,0,   0,   1,    0,   1, 0,0,0,0, ST_PAUSED);
    add(0,0,1,0,   0,   0,    0,   1, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,    0,   0, 0,0,1,1, ST_ALARM);
    add(0,0,0,0,   0,   0,    0,   0, 0,0,1,0, ST_ALARM);
    add(1,0,0,0,   0,   0,    0,   0, 0,0,1,0, ST_ALARM);
    add(0,1,0,0,   0,  30,    0,  30, 0,0,0,0, ST_IDLE);
    add(0,0,1,1,   0,   0,    0,  30, 0,0,0,0, ST_IDLE);
    add(1,0,0,0,   0,   0,    0,  30, 0,0,0,0, ST_IDLE);
    add(0,1,0,0,   0,   0,    0,   0, 0,0,0,0, ST_IDLE);
    add(0,0,1,0,   0,   0,    0,   0, 0,0,0,0, ST_IDLE);
    add(0,1,0,0, 200,   5,   59,   5, 0,0,0,0, ST_IDLE);
    // pause acknowledges alarm; tick+load in IDLE
    add(0,1,0,0,   0,   1,    0,   1, 0,0,0,0, ST_IDLE);
    add(0,0,1,0,   0,   0,    0,   1, 0,1,0,0, ST_RUN);
    add(1,0,0,0,   0,   0,    0,   0, 0,0,1,1, ST_ALARM);
    add(0,0,0,1,   0,   0,    0,   0, 0,0,0,0, ST_IDLE);
    add(1,1,0,0,   0,   7,    0,   7, 0,0,0,0, ST_IDLE);
    // tick reaching 00:00 beats pause; start acknowledges alarm
    add(0,1,0,0,   0,   1,    0,   1, 0,0,0,0, ST_IDLE);
    add(0,0,1,0,   0,   0,    0,   1, 0,1,0,0, ST_RUN);
    add(1,0,0,1,   0,   0,    0,   0, 0,0,1,1, ST_ALARM);
    add(0,0,1,0,   0,   0,    0,   0, 0,0,0,0, ST_IDLE);

    // Reset state while RESET is held low.
    #12;
    z.emin = 0; z.esec = 0; z.eb = 0; z.er = 0; z.ea = 0; z.ed = 0; z.st = ST_IDLE;
    check_all("reset", z);
    @(posedge clk); #1;
    RESET = 1'b1;

    for (int i = 0; i < q.size(); i++)
      apply($sformatf("vec%0d", i), q[i]);

    // Asynchronous reset in the middle of RUN at 12:34.
    z.t = 0; z.l = 1; z.s = 0; z.p = 0; z.lmin = 12; z.lsec = 35;
    z.emin = 12; z.esec = 35; z.eb = 0; z.er = 0; z.ea = 0; z.ed = 0; z.st = ST_IDLE;
    apply("mid_load", z);
    z.l = 0; z.s = 1; z.er = 1; z.st = ST_RUN;
    apply("mid_start", z);
    z.s = 0; z.t = 1; z.esec = 34;
    apply("mid_tick", z);
    tick = 1'b1;
    #2 RESET = 1'b0;
    #1;
    tick = 1'b0;
    z.emin = 0; z.esec = 0; z.eb = 0; z.er = 0; z.ea = 0; z.ed = 0; z.st = ST_IDLE;
    check_all("async_rst", z);
    @(posedge clk); #1;
    check_all("rst_hold", z);
    RESET = 1'b1;
    z.t = 1; z.l = 0; z.s = 0; z.p = 0; z.lmin = 0; z.lsec = 0;
    for (int k = 0; k < 3; k++)
      apply($sformatf("post_rst%0d", k), z);
    z.t = 0; z.s = 1;
    apply("post_rst_start", z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown (min:sec) timer for the watch: the down-counting counterpart of the mod-60 up-counter chain. A mod-60 seconds stage borrows from a minutes stage, and the block raises an alarm on reaching 00:00. It sits beside the timekeeping counters, is clocked by the system clock, and advances only on a one-cycle 1 Hz `tick` enable, so all logic is in one clock domain.

## Interface
- `MAX_MIN`, default 59: largest loadable minutes value.
- `ALARM_TICKS`, default 10: number of `tick` pulses the alarm stays asserted.
- `clk` in 1: system clock, rising edge.
- `RESET` in 1: reset, asynchronous, active-low.
- `tick` in 1: 1 Hz enable, one `clk` cycle wide.
- `load` in 1: load `load_min`/`load_sec` into the counters.
- `load_min` in 8: binary minutes preset.
- `load_sec` in 8: binary seconds preset.
- `start` in 1: pulse; begin or resume counting.
- `pause` in 1: pulse; suspend counting.
- `sec_num` out 8: current seconds, binary 0..59.
- `min_num` out 8: current minutes, binary 0..MAX_MIN.
- `borrow` out 1: one-cycle pulse when seconds wrap 0→59.
- `running` out 1: high in RUN.
- `alarm` out 1: high in ALARM.
- `done` out 1: one-cycle pulse on the RUN→ALARM transition.

## Operation
- States: IDLE, RUN, PAUSED, ALARM.
- **IDLE**
  - `load` → counters take the clamped presets: sec is limited to 59, min to MAX_MIN.
  - `start` with time ≠ 00:00 → RUN.
  - `start` at 00:00 is ignored.
- **RUN**, on `tick`:
  - If sec > 0: sec−1.
  - Else if min > 0: sec←59, min−1, `borrow`=1.
  - If the new value is 00:00: → ALARM, `done`=1.
  - `pause` → PAUSED.
  - `load` is ignored in RUN.
- **PAUSED**
  - Counters hold.
  - `load` is accepted.
  - `start` with time ≠ 00:00 → RUN.
- **ALARM**
  - Counters hold at 00:00.
  - An internal tick counter runs from 0; after ALARM_TICKS ticks → IDLE.
  - `start`, `pause` or `load` acknowledges the alarm → IDLE. If the acknowledge is `load`, the presets are loaded in the same cycle.
- **Simultaneous events**
  - `start` and `pause` in the same cycle: `pause` wins; no RUN entry from IDLE/PAUSED, and RUN→PAUSED.
  - `tick` and `pause` in RUN in the same cycle: the decrement is applied, then PAUSED.
  - `tick` and `load` in IDLE/PAUSED: the load wins.
  - `tick` causing 00:00 together with `pause`: → ALARM; `pause` is ignored.
- **Arithmetic**: unsigned 8-bit. Loaded values are clamped before storage, so counters never exceed their range and never underflow.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - `sec_num`=0, `min_num`=0
  - `borrow`=0, `running`=0, `alarm`=0, `done`=0
  - alarm tick counter 0
- `RESET` low mid-operation clears everything immediately (asynchronously); no pending event survives.
- Latency:
  - `tick` in cycle N → new count, `borrow` and `done` visible in cycle N+1.
  - `start`/`pause`/`load` in cycle N → state/counters updated in N+1.
- `borrow` and `done` are high for exactly one `clk` cycle.
- `running` and `alarm` decode the state register.
- The alarm lasts ALARM_TICKS `tick` pulses, counted from the first `tick` after entering ALARM.

## Structure
- Package `countdown_pkg`:
  - state enum (IDLE, RUN, PAUSED, ALARM)
  - `SEC_MAX`=59
  - `ALARM_CNT_W` width helper
- Sub-module `down_counter_mod`:
  - Parameter MODULUS.
  - Inputs: `en`, `load`, `load_val`.
  - Outputs: `count`, `zero`, `borrow`; `borrow` fires on 0→MODULUS−1 when enabled.
  - Used once for seconds (MODULUS 60).
  - Minutes are decremented in the top level, gated by the seconds borrow and min > 0.
- Top level holds the FSM, clamping and the alarm tick counter.

## Test plan
- Reset, load 01:02, start, 3 ticks → 01:01, 01:00, 00:59. `borrow` pulses on the third tick only.
- Load 00:02, start, 2 ticks → 00:00; `done` pulses once and `alarm`=1. Then 10 ticks → `alarm`=0, state IDLE.
- Load 00:05, start, 2 ticks, then `pause` together with a tick → 00:02 and PAUSED. Further ticks hold 00:02; `start` resumes.
- Load sec=75, min=200 (MAX_MIN=59) → 59:59 stored. `load` while RUN is ignored. `start` at 00:00 stays IDLE.
- In ALARM, pulse `load` with 00:30 → IDLE, 00:30, `alarm`=0 next cycle. `start`+`pause` in the same cycle from IDLE → stays IDLE.
- Assert `RESET` mid-RUN at 12:34 → all outputs 0 and IDLE immediately. After release, ticks do not count.
